// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } dmem_state_t;

   // Wide enough for any supported DATA_W; the top slices the width it needs.
   localparam int DMEM_BE_MAX = 64;
   localparam logic [DMEM_BE_MAX-1:0] BE_ALL = '1;

   localparam int DMEM_WAIT_W = 8;

endpackage

// File: rtl/dmem_bus_ctrl.sv
// Moves one whole word per LSU request onto an Avalon-style bus with waitrequest.
// Latency: strobe the cycle after accept, rsp_valid one cycle after the strobe completes (+1 per wait cycle).
// Backpressure: mem_waitrequest freezes all bus outputs; stall holds the CPU. DMEM_TIMEOUT_EN adds a wait abort.
module dmem_bus_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_byteen,
   output logic                stall,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_read,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic [DATA_W/8-1:0] mem_byteenable,
   input  logic                mem_waitrequest,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int BE_W = DATA_W / 8;

   dmem_state_t state;
   logic        timeout;

   // The CPU is released in the DONE cycle so it can advance while we idle.
   assign stall = req_valid && (state != DONE);

`ifdef DMEM_TIMEOUT_EN
   localparam int WAIT_W = (DMEM_WAIT_W > $clog2(MAX_WAIT + 1)) ? DMEM_WAIT_W : $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] wait_cnt;

   assign timeout = mem_waitrequest && ((wait_cnt + WAIT_W'(1)) == WAIT_W'(MAX_WAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else if ((state == RD || state == WR) && mem_waitrequest) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err <= 1'b0;
      end else begin
         rsp_err <= (state == RD || state == WR) && timeout;
      end
   end
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_address    <= '0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
         rsp_valid      <= 1'b0;
         rsp_rdata      <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (!req_write) begin
                     state          <= RD;
                     mem_address    <= req_addr & ~ADDR_W'(3);
                     mem_byteenable <= BE_ALL[BE_W-1:0];
                     mem_read       <= 1'b1;
                  end else if (req_byteen != '0) begin
                     state          <= WR;
                     mem_address    <= req_addr & ~ADDR_W'(3);
                     mem_writedata  <= req_wdata;
                     mem_byteenable <= req_byteen;
                     mem_write      <= 1'b1;
                  end else begin
                     // Nothing to write: complete without touching the bus.
                     state     <= DONE;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            RD: begin
               if (!mem_waitrequest) begin
                  rsp_rdata <= mem_readdata;
                  mem_read  <= 1'b0;
                  state     <= DONE;
                  rsp_valid <= 1'b1;
               end else if (timeout) begin
                  mem_read  <= 1'b0;
                  state     <= DONE;
                  rsp_valid <= 1'b1;
               end
            end
            WR: begin
               if (!mem_waitrequest || timeout) begin
                  mem_write <= 1'b0;
                  state     <= DONE;
                  rsp_valid <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed scoreboard bench for dmem_bus_ctrl; timeout steps build only with DMEM_TIMEOUT_EN.
module tb_dmem_bus_ctrl;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BW-1:0] req_byteen;
   logic          stall;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_address;
   logic          mem_read;
   logic          mem_write;
   logic [DW-1:0] mem_writedata;
   logic [BW-1:0] mem_byteenable;
   logic          mem_waitrequest;
   logic [DW-1:0] mem_readdata;

   dmem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_byteen      (req_byteen),
      .stall           (stall),
      .rsp_valid       (rsp_valid),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .mem_address     (mem_address),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_writedata   (mem_writedata),
      .mem_byteenable  (mem_byteenable),
      .mem_waitrequest (mem_waitrequest),
      .mem_readdata    (mem_readdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   longint        cyc = 0;
   longint        strobe_cyc = 0;
   longint        prev_strobe_cyc = 0;
   logic [DW-1:0] last_rdata;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request at the current cycle (entered just after a rising edge)
   // and checks every cycle until completion against the expected timeline.
   task automatic txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input logic [BW-1:0] be, input logic [DW-1:0] rdata,
                      input int nwait, input logic to);
      logic bus;
      int   last_s;
      int   done;
      exp_t e;
      bus = !(wr && (be == '0));
      if (!bus) begin
         last_s = 0;
         done   = 1;
      end else if (to) begin
         last_s = MW;
         done   = MW + 1;
      end else begin
         last_s = 1 + nwait;
         done   = 2 + nwait;
      end
      e.rdata    = (bus && !wr && !to) ? rdata : last_rdata;
      e.err      = to;
      last_rdata = e.rdata;
      sb.push_back(e);

      req_valid       = 1'b1;
      req_write       = wr;
      req_addr        = addr;
      req_wdata       = wdata;
      req_byteen      = be;
      mem_waitrequest = 1'b0;
      mem_readdata    = rdata;

      for (int k = 0; k <= done; k++) begin
         logic strobe;
         @(negedge clk);
         strobe = bus && (k >= 1) && (k <= last_s);
         chk("stall", 32'(stall), 32'(k != done));
         chk("mem_read", 32'(mem_read), 32'(strobe && !wr));
         chk("mem_write", 32'(mem_write), 32'(strobe && wr));
         if (strobe) begin
            chk("mem_address", mem_address, addr & ~32'h3);
            chk("mem_byteenable", 32'(mem_byteenable), 32'(wr ? be : 4'hF));
            if (wr) chk("mem_writedata", mem_writedata, wdata);
            if (k == 1) strobe_cyc = cyc;
         end
         chk("rsp_valid", 32'(rsp_valid), 32'(k == done));
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("rsp_rdata", rsp_rdata, x.rdata);
               chk("rsp_err", 32'(rsp_err), 32'(x.err));
            end
         end
         if (k < done) begin
            @(posedge clk);
            #1;
            mem_waitrequest = ((k + 1) >= 1) && ((k + 1) <= nwait);
            mem_readdata    = mem_waitrequest ? 32'hBAD0_BAD0 : rdata;
         end
      end
      chk("rsp_missing", 32'(sb.size()), 32'h0);
      sb.delete();
      @(posedge clk);
      #1;
      req_valid       = 1'b0;
      mem_waitrequest = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n           = 1'b0;
      req_valid       = 1'b0;
      req_write       = 1'b0;
      req_addr        = '0;
      req_wdata       = '0;
      req_byteen      = '0;
      mem_waitrequest = 1'b0;
      mem_readdata    = '0;
      last_rdata      = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_read", 32'(mem_read), 32'h0);
      chk("rst_mem_write", 32'(mem_write), 32'h0);
      chk("rst_mem_address", mem_address, 32'h0);
      chk("rst_mem_writedata", mem_writedata, 32'h0);
      chk("rst_mem_byteenable", 32'(mem_byteenable), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Zero-wait read
      txn(1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 1'b0);
      // Unaligned write, one byte lane, three wait cycles
      txn(1'b1, 32'h0000_2003, 32'h1122_3344, 4'b0100, 32'h0, 3, 1'b0);
      // Write with no byte lanes: no bus cycle
      txn(1'b1, 32'h0000_2100, 32'hFFFF_FFFF, 4'b0000, 32'h0, 0, 1'b0);

      // Back-to-back read then write
      txn(1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 1'b0);
      prev_strobe_cyc = strobe_cyc;
      txn(1'b1, 32'h0000_3008, 32'hA5A5_5A5A, 4'hF, 32'h0, 0, 1'b0);
      chk("b2b_gap", 32'(strobe_cyc - prev_strobe_cyc), 32'd3);

      // Read with two wait cycles
      txn(1'b0, 32'h0000_3ffe, 32'h0, 4'h0, 32'h1357_9BDF, 2, 1'b0);

      // Reset while the read is stuck in waitrequest
      req_valid       = 1'b1;
      req_write       = 1'b0;
      req_addr        = 32'h0000_4000;
      mem_waitrequest = 1'b1;
      mem_readdata    = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_rst_pre_read", 32'(mem_read), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_read_drop", 32'(mem_read), 32'h0);
      chk("mid_rst_stall_idle", 32'(stall), 32'h1);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
      req_valid       = 1'b0;
      mem_waitrequest = 1'b0;
      last_rdata      = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("post_rst_mem_read", 32'(mem_read), 32'h0);
      end
      @(posedge clk);
      #1;

      // Recovery after reset
      txn(1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h0BAD_CAFE, 1, 1'b0);

`ifdef DMEM_TIMEOUT_EN
      // Stuck slave: abort after MW wait cycles, read data untouched
      txn(1'b0, 32'h0000_6000, 32'h0, 4'h0, 32'h7777_7777, 1000, 1'b1);
      txn(1'b1, 32'h0000_6004, 32'h8888_8888, 4'b0011, 32'h0, 1000, 1'b1);
      // Normal traffic still works after an abort
      txn(1'b0, 32'h0000_6008, 32'h0, 4'h0, 32'h2468_ACE0, 2, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
